// File: rtl/fetch_stage.sv
// Instruction fetch stage with a single outstanding memory request and a
// one-entry skid buffer that catches a response arriving while decode stalls.
//
// Parameters:
//   RESET_PC    fetch address loaded on reset
//   NOP_INSTR   instruction word presented for a bubble
// Ports:
//   Clock        rising-edge clock
//   nReset       synchronous active-low reset
//   stall        hold IF/ID outputs, no new issue
//   flush        taken branch/jump: drop in-flight fetch and buffered word
//   redirect_pc  new fetch address, valid with flush
//   imem_req     fetch request strobe (combinational, one cycle per request)
//   imem_addr    word-aligned fetch address
//   imem_rvalid  response strobe
//   imem_rdata   instruction word, valid with imem_rvalid
//   PC_out       PC of the instruction presented to decode
//   instr_out    instruction presented to decode
//   valid_out    1 = real instruction, 0 = bubble
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] instr_out,
    output logic        valid_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;  // waiting to discard a flushed response

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic        buf_full_q, buf_full_d;
    logic [31:0] pc_out_d, instr_out_d;
    logic        valid_out_d;
    logic        issue;

    // Low address bits of the redirect target are discarded on purpose.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc[1:0];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        buf_full_d  = buf_full_q;
        pc_out_d    = PC_out;
        instr_out_d = instr_out;
        valid_out_d = valid_out;
        issue       = 1'b0;

        if (flush) begin
            // Flush wins over stall and never issues in the same cycle.
            pc_d        = {redirect_pc[31:2], 2'b00};
            pc_out_d    = 32'h0;
            instr_out_d = NOP_INSTR;
            valid_out_d = 1'b0;
            buf_full_d  = 1'b0;
            if (state_q == ST_WAIT || state_q == ST_DROP) begin
                state_d = imem_rvalid ? ST_IDLE : ST_DROP;
            end
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (stall) begin
                            buf_pc_d    = req_pc_q;
                            buf_instr_d = imem_rdata;
                            buf_full_d  = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            pc_out_d    = req_pc_q;
                            instr_out_d = imem_rdata;
                            valid_out_d = 1'b1;
                            issue       = 1'b1;  // back-to-back fetch
                        end
                    end else if (!stall) begin
                        pc_out_d    = 32'h0;
                        instr_out_d = NOP_INSTR;
                        valid_out_d = 1'b0;
                    end
                end
                ST_DROP: begin
                    if (!stall) begin
                        pc_out_d    = 32'h0;
                        instr_out_d = NOP_INSTR;
                        valid_out_d = 1'b0;
                    end
                    if (imem_rvalid) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    // IDLE: drain the skid buffer before fetching anew.
                    if (!stall) begin
                        if (buf_full_q) begin
                            pc_out_d    = buf_pc_q;
                            instr_out_d = buf_instr_q;
                            valid_out_d = 1'b1;
                            buf_full_d  = 1'b0;
                        end else begin
                            pc_out_d    = 32'h0;
                            instr_out_d = NOP_INSTR;
                            valid_out_d = 1'b0;
                            issue       = 1'b1;
                        end
                    end
                end
            endcase

            if (issue) begin
                req_pc_d = pc_q;
                pc_d     = pc_q + 32'd4;  // wraps modulo 2^32
                state_d  = ST_WAIT;
            end
        end
    end

    assign imem_req  = issue & nReset;
    assign imem_addr = {pc_q[31:2], 2'b00};

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            req_pc_q    <= 32'h0;
            buf_pc_q    <= 32'h0;
            buf_instr_q <= 32'h0;
            buf_full_q  <= 1'b0;
            PC_out      <= 32'h0;
            instr_out   <= NOP_INSTR;
            valid_out   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            buf_full_q  <= buf_full_d;
            PC_out      <= pc_out_d;
            instr_out   <= instr_out_d;
            valid_out   <= valid_out_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed stimulus pushes hand-computed
// request addresses and decoded instructions into queues; a monitor pops and
// compares whenever the DUT issues a request or presents a fresh valid word.
// Memory model returns the address as data after a programmable latency.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        Clock = 1'b0;
    logic        nReset, stall, flush;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] PC_out, instr_out;
    logic        valid_out;

    // Second instance for the wrap-around reset address.
    logic        stall2, flush2;
    logic [31:0] redirect2;
    logic        imem_req2, imem_rvalid2;
    logic [31:0] imem_addr2, imem_rdata2;
    logic [31:0] pc_out2, instr_out2;
    logic        valid_out2;

    int n_pass  = 0;
    int n_total = 0;
    int lat     = 1;

    logic [31:0] exp_req[$];
    logic [31:0] exp_instr[$];

    always #5 Clock = ~Clock;

    fetch_stage dut (
        .Clock(Clock), .nReset(nReset), .stall(stall), .flush(flush),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .PC_out(PC_out),
        .instr_out(instr_out), .valid_out(valid_out)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
        .Clock(Clock), .nReset(nReset), .stall(stall2), .flush(flush2),
        .redirect_pc(redirect2), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2), .PC_out(pc_out2),
        .instr_out(instr_out2), .valid_out(valid_out2)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Memory for the main DUT: request seen mid-cycle, response driven
    // just after the edge that ends the last latency cycle.
    initial begin : mem_main
        logic        pend;
        int          cnt;
        logic [31:0] maddr;
        pend        = 1'b0;
        cnt         = 0;
        maddr       = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge Clock);
            if (imem_req) begin
                pend  = 1'b1;
                cnt   = lat;
                maddr = imem_addr;
            end
            @(posedge Clock);
            #1;
            imem_rvalid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = maddr;
                    pend        = 1'b0;
                end
            end
        end
    end

    initial begin : mem_wrap
        logic        r;
        logic [31:0] a;
        stall2       = 1'b0;
        flush2       = 1'b0;
        redirect2    = 32'h0;
        imem_rvalid2 = 1'b0;
        imem_rdata2  = 32'h0;
        forever begin
            @(negedge Clock);
            r = imem_req2;
            a = imem_addr2;
            @(posedge Clock);
            #1;
            imem_rvalid2 = r;
            imem_rdata2  = a;
        end
    end

    // Monitor: outputs registered at an edge whose cycle had stall (no flush)
    // are a held copy, not a new presentation.
    initial begin : monitor
        logic        hold_prev;
        logic [31:0] e;
        hold_prev = 1'b0;
        forever begin
            @(negedge Clock);
            #1;
            if (!nReset) begin
                check("req_in_reset", {31'h0, imem_req}, 32'h0);
            end else if (imem_req) begin
                if (exp_req.size() == 0) begin
                    check("unexpected_req", imem_addr, 32'hDEAD_BEEF);
                end else begin
                    e = exp_req.pop_front();
                    check("req_addr", imem_addr, e);
                end
            end
            if (valid_out && !hold_prev) begin
                if (exp_instr.size() == 0) begin
                    check("unexpected_valid", PC_out, 32'hDEAD_BEEF);
                end else begin
                    e = exp_instr.pop_front();
                    check("pc_out", PC_out, e);
                    check("instr_out", instr_out, e);
                end
            end
            hold_prev = nReset && stall && !flush;
        end
    end

    initial begin : monitor_wrap
        logic [31:0] exp2 [3];
        int n2;
        exp2[0] = 32'hFFFF_FFFC;
        exp2[1] = 32'h0000_0000;
        exp2[2] = 32'h0000_0004;
        n2 = 0;
        forever begin
            @(negedge Clock);
            #1;
            if (nReset && imem_req2 && n2 < 3) begin
                check("wrap_req_addr", imem_addr2, exp2[n2]);
                n2++;
            end
        end
    end

    task automatic cyc(input logic rst_n, input logic st, input logic fl, input logic [31:0] rpc);
        @(posedge Clock);
        #2;
        nReset      = rst_n;
        stall       = st;
        flush       = fl;
        redirect_pc = rpc;
    endtask

    task automatic chk_out(input string nm, input logic [31:0] epc, input logic [31:0] ei,
                           input logic ev);
        @(negedge Clock);
        #1;
        check({nm, "_pc"}, PC_out, epc);
        check({nm, "_instr"}, instr_out, ei);
        check({nm, "_valid"}, {31'h0, valid_out}, {31'h0, ev});
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        nReset      = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect_pc = 32'h0;

        // Requests: streaming, stall/buffer, flush to 0x100, flush+stall to
        // 0x200, then restart after a mid-WAIT reset.
        exp_req = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100, 32'h104,
                    32'h200, 32'h204, 32'h208, 32'h0, 32'h4, 32'h8};
        // Words reaching decode; 0x10/0x104/0x208 are discarded.
        exp_instr = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h200, 32'h204,
                      32'h0, 32'h4};

        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk_out("reset", 32'h0, NOP, 1'b0);

        cyc(1, 0, 0, 0);                       // c0: req 0x0
        cyc(1, 0, 0, 0);                       // c1: resp 0x0, req 0x4
        cyc(1, 0, 0, 0);                       // c2: resp 0x4, req 0x8
        cyc(1, 1, 0, 0);                       // c3: resp 0x8 buffered
        cyc(1, 1, 0, 0); chk_out("stall_hold1", 32'h4, 32'h4, 1'b1);
        cyc(1, 1, 0, 0); chk_out("stall_hold2", 32'h4, 32'h4, 1'b1);
        cyc(1, 0, 0, 0); chk_out("stall_hold3", 32'h4, 32'h4, 1'b1);  // drain buffer
        cyc(1, 0, 0, 0);                       // c7: req 0xC
        cyc(1, 0, 0, 0); lat = 2;              // c8: resp 0xC, req 0x10 slow
        cyc(1, 0, 1, 32'h100); lat = 1;        // c9: flush while pending
        cyc(1, 0, 0, 0); chk_out("flush_bubble", 32'h0, NOP, 1'b0);   // late resp dropped
        cyc(1, 0, 0, 0); chk_out("drop_bubble", 32'h0, NOP, 1'b0);    // req 0x100
        cyc(1, 0, 0, 0);                       // c12: resp 0x100, req 0x104
        cyc(1, 1, 0, 0);                       // c13: resp 0x104 buffered
        cyc(1, 1, 1, 32'h200);                 // c14: flush+stall drops buffer
        cyc(1, 0, 0, 0); chk_out("flush_stall_bubble", 32'h0, NOP, 1'b0);
        cyc(1, 0, 0, 0);                       // c16: resp 0x200, req 0x204
        cyc(1, 0, 0, 0); lat = 2;              // c17: resp 0x204, req 0x208 slow
        cyc(0, 0, 0, 0); lat = 1;              // c18: reset during WAIT
        cyc(1, 0, 0, 0); chk_out("post_reset", 32'h0, NOP, 1'b0);     // late resp ignored
        cyc(1, 0, 0, 0);                       // c20: resp 0x0, req 0x4
        cyc(1, 0, 0, 0);                       // c21: resp 0x4, req 0x8
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        @(negedge Clock);
        #2;

        check("req_queue_drained", exp_req.size(), 32'h0);
        check("instr_queue_drained", exp_instr.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address loaded on reset.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0013, instruction word presented for a bubble (addi x0,x0,0).
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 Clock  in  1  rising-edge clock.
REQ-005 nReset  in  1  synchronous active-low reset.
REQ-006 stall  in  1  hold IF/ID outputs; no new issue.
REQ-007 flush  in  1  branch/jump taken; discard in-flight fetch and buffered word.
REQ-008 redirect_pc  in  32  new fetch address, valid when flush=1.
REQ-009 imem_req  out  1  fetch request, one cycle per request.
REQ-010 imem_addr  out  32  word-aligned fetch address, valid when imem_req=1.
REQ-011 imem_rvalid  in  1  response strobe, at least 1 cycle after the request.
REQ-012 imem_rdata  in  32  instruction word, valid when imem_rvalid=1.
REQ-013 PC_out  out  32  PC of the instruction presented to decode.
REQ-014 instr_out  out  32  instruction presented to decode.
REQ-015 valid_out  out  1  1 = real instruction, 0 = bubble.

Function
REQ-016 The block SHALL hold fetch PC (pc), request PC (req_pc), a one-entry skid buffer (buf_pc, buf_instr, buf_full) and FSM states IDLE, WAIT, DROP.
REQ-017 At most one memory request SHALL be outstanding.
REQ-018 imem_req SHALL be combinational: 1 only when a request is issued this cycle; imem_addr = {pc[31:2],2'b00}.
REQ-019 IDLE: if !flush && !stall && !buf_full, issue (req_pc<=pc, pc<=pc+4, ->WAIT); otherwise remain IDLE, no request.
REQ-020 WAIT, imem_rvalid=0: no request; remain WAIT.
REQ-021 WAIT, imem_rvalid=1, !stall, !flush: IF/ID <= {req_pc, imem_rdata, 1}; issue next request the same cycle (stay WAIT), giving one instruction per cycle with 1-cycle memory latency.
REQ-022 WAIT, imem_rvalid=1, stall, !flush: buf <= {req_pc, imem_rdata}, buf_full<=1, IF/ID hold, ->IDLE.
REQ-023 stall=1 SHALL hold PC_out/instr_out/valid_out unchanged (unless flush).
REQ-024 !stall with buf_full=1: IF/ID <= buffer with valid 1, buf_full<=0, no issue that cycle.
REQ-025 !stall with no response and buffer empty: IF/ID <= {32'h0, NOP_INSTR, 0}.
REQ-026 flush overrides stall: pc <= {redirect_pc[31:2],2'b00}; IF/ID <= {0, NOP_INSTR, 0}; buf_full<=0; no request this cycle.
REQ-027 flush in WAIT with imem_rvalid=0 SHALL go to DROP; with imem_rvalid=1, the response is discarded and the state goes to IDLE.
REQ-028 DROP: no request; on imem_rvalid the response is discarded and the state goes to IDLE; flush in DROP updates pc and stays DROP.
REQ-029 imem_rvalid in IDLE SHALL be ignored.
REQ-030 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-031 PC_out of each valid instruction SHALL equal the address issued for it, including across stall and buffer paths.

Reset
REQ-032 On a rising Clock edge with nReset=0: pc<=RESET_PC, state<=IDLE, buf_full<=0, PC_out<=0, instr_out<=NOP_INSTR, valid_out<=0.
REQ-033 imem_req SHALL be 0 in any cycle with nReset=0.
REQ-034 Reset during WAIT/DROP SHALL abandon the outstanding request; a late imem_rvalid arrives in IDLE and is ignored.
REQ-035 First request SHALL issue in the first cycle with nReset=1, stall=0, flush=0, at RESET_PC.

Verification
REQ-036 Reset release, 1-cycle memory returning addr-as-data, stall=0 -> requests at 0x0,0x4,0x8; valid_out=1 from cycle 2 with PC_out/instr_out 0x0,0x4,0x8, one per cycle.
REQ-037 stall=1 in the cycle 0x8's response arrives, for 3 cycles -> IF/ID holds 0x4; 0x8 buffered; no imem_req while stalled; on release 0x8 presented, then request 0xC.
REQ-038 flush with redirect_pc=0x100 while WAIT with response pending -> IF/ID bubble (valid 0, NOP_INSTR); late response discarded; next request addr 0x100; next valid PC_out 0x100.
REQ-039 flush and stall same cycle with buf_full=1 -> buffer dropped, pc=redirect_pc, bubble presented.
REQ-040 RESET_PC=32'hFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000.
REQ-041 nReset=0 for one cycle during WAIT, memory responds next cycle -> response ignored; outputs at reset values; fetch restarts at RESET_PC.
